// File: rtl/bcd_ctrl_pkg.sv
// Shared definitions for the BCD counter controller.
//   - command opcodes carried on cmd_op
//   - controller state encoding
//   - largest legal value of a BCD digit
package bcd_ctrl_pkg;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_inc.sv
// Combinational increment of a single BCD digit.
// Ports:
//   digit_in  - current digit value (0..9)
//   carry_in  - increment request from the lower digit (1 for digit 0)
//   digit_out - digit value after the optional increment
//   carry_out - this digit wraps 9->0, so the next digit must increment
module bcd_digit_inc
  import bcd_ctrl_pkg::*;
(
  input  logic [3:0] digit_in,
  input  logic       carry_in,
  output logic [3:0] digit_out,
  output logic       carry_out
);

  always_comb begin
    digit_out = digit_in;
    carry_out = 1'b0;
    if (carry_in) begin
      if (digit_in == BCD_MAX) begin
        digit_out = 4'd0;
        carry_out = 1'b1;
      end else begin
        digit_out = digit_in + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_ctrl.sv
// Command-driven controller for a DIGITS-wide BCD event counter.
// Ports:
//   clock, clear_n       - clock and synchronous active-low reset
//   cmd_valid/cmd_ready  - command handshake; cmd_op selects START/STOP/LOAD/CLEAR
//   load_value           - preset used by LOAD (digit 0 in bits [3:0])
//   limit, reload        - terminal count and auto-reload/one-shot select
//   tick                 - count event, one increment per cycle high
//   count                - current BCD count
//   running              - high while in RUN
//   done, overflow, err  - single-cycle event pulses
module bcd_counter_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [4*DIGITS-1:0]   limit,
  input  logic                  reload,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  overflow,
  output logic                  err
);

  localparam int CW = 4 * DIGITS;

  // True when every nibble of v is a legal BCD digit.
  function automatic logic is_bcd(input logic [CW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic            overflow_q, overflow_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;

  logic [CW-1:0]   count_inc;
  logic [DIGITS:0] carry;
  logic            accept;
  logic            limit_hit;
  logic            all_nines;

  // Ripple chain: digit 0 always increments, higher digits on carry.
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_inc u_inc (
      .digit_in  (count_q[4*g +: 4]),
      .carry_in  (carry[g]),
      .digit_out (count_inc[4*g +: 4]),
      .carry_out (carry[g+1])
    );
  end

  // Carry out of the top digit means every digit was 9.
  assign all_nines = carry[DIGITS];
  // A limit holding a non-BCD nibble must never match.
  assign limit_hit = is_bcd(limit) && (count_q == limit);
  assign accept    = cmd_valid && ready_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    done_d     = 1'b0;
    overflow_d = 1'b0;
    err_d      = 1'b0;
    ready_d    = !accept;

    if (accept) begin
      // Commands win over a same-cycle tick; the tick is dropped.
      case (cmd_op)
        CMD_START: begin
          if (state_q == ST_DONE) begin
            count_d = '0;
            state_d = ST_RUN;
          end else if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
          end
        end
        CMD_STOP: begin
          state_d = ST_IDLE;
        end
        CMD_LOAD: begin
          if ((state_q == ST_IDLE) && is_bcd(load_value)) begin
            count_d = load_value;
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          count_d = '0;
          state_d = ST_IDLE;
        end
      endcase
    end else if (tick && (state_q == ST_RUN)) begin
      if (limit_hit) begin
        done_d = 1'b1;
        if (reload) begin
          count_d = '0;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        count_d    = count_inc;
        overflow_d = all_nines;
      end
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      running_q  <= running_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign count     = count_q;
  assign running   = running_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign err       = err_q;
  assign cmd_ready = ready_q;

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Directed bench for bcd_counter_ctrl with DIGITS=2. The driver applies one
// vector per clock and pushes the hand-computed post-edge outputs into a
// queue; an independent monitor pops and compares on every falling edge.
module tb_bcd_counter_ctrl;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic       clock = 1'b0;
  logic       clear_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] load_value;
  logic [7:0] limit;
  logic       reload;
  logic       tick;
  logic [7:0] count;
  logic       running;
  logic       done;
  logic       overflow;
  logic       err;

  typedef struct {
    string      name;
    logic [7:0] cnt;
    logic       run;
    logic       dn;
    logic       ov;
    logic       er;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  bcd_counter_ctrl #(.DIGITS(2)) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .load_value (load_value),
    .limit      (limit),
    .reload     (reload),
    .tick       (tick),
    .count      (count),
    .running    (running),
    .done       (done),
    .overflow   (overflow),
    .err        (err)
  );

  // Monitor: one expected entry per clock, checked away from the active edge.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (count !== e.cnt || running !== e.run || done !== e.dn ||
          overflow !== e.ov || err !== e.er || cmd_ready !== e.rdy) begin
        n_bad++;
        $display("FAIL %s: got cnt=%h run=%b done=%b ovf=%b err=%b rdy=%b, want cnt=%h run=%b done=%b ovf=%b err=%b rdy=%b",
                 e.name, count, running, done, overflow, err, cmd_ready,
                 e.cnt, e.run, e.dn, e.ov, e.er, e.rdy);
      end
    end
  end

  // Apply one cycle of stimulus and queue the outputs expected after the edge.
  task automatic step(input string nm, input logic v, input logic [1:0] op,
                      input logic [7:0] lv, input logic tk,
                      input logic [7:0] ec, input logic erun, input logic edn,
                      input logic eov, input logic eer, input logic erdy);
    exp_t e;
    cmd_valid  = v;
    cmd_op     = op;
    load_value = lv;
    tick       = tk;
    @(posedge clock);
    e.name = nm; e.cnt = ec; e.run = erun; e.dn = edn;
    e.ov = eov; e.er = eer; e.rdy = erdy;
    q.push_back(e);
    #1;
  endtask

  // Plain tick cycle and idle cycle shorthands.
  task automatic tk(input string nm, input logic [7:0] ec, input logic erun,
                    input logic edn, input logic eov);
    step(nm, 1'b0, OP_START, 8'h00, 1'b1, ec, erun, edn, eov, 1'b0, 1'b1);
  endtask

  task automatic nop(input string nm, input logic [7:0] ec, input logic erun);
    step(nm, 1'b0, OP_START, 8'h00, 1'b0, ec, erun, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic cmd(input string nm, input logic [1:0] op, input logic [7:0] lv,
                     input logic tkin, input logic [7:0] ec, input logic erun,
                     input logic eer);
    step(nm, 1'b1, op, lv, tkin, ec, erun, 1'b0, 1'b0, eer, 1'b0);
  endtask

  logic [7:0] r_cnt [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00,
                             8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00};
  logic       r_dn  [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

  initial begin
    clear_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_START; load_value = '0;
    limit = 8'hFF; reload = 1'b0; tick = 1'b0;
    #1;
    step("reset0", 1'b1, OP_LOAD, 8'h55, 1'b1, 8'h00, 0, 0, 0, 0, 1);
    step("reset1", 1'b0, OP_START, 8'h00, 1'b0, 8'h00, 0, 0, 0, 0, 1);
    clear_n = 1'b1;

    // LOAD 37, START, five ticks -> 42
    cmd("load37", OP_LOAD, 8'h37, 1'b0, 8'h37, 0, 0);
    nop("idle37", 8'h37, 0);
    cmd("start37", OP_START, 8'h00, 1'b0, 8'h37, 1, 0);
    tk("t38", 8'h38, 1, 0, 0);
    tk("t39", 8'h39, 1, 0, 0);
    tk("t40", 8'h40, 1, 0, 0);
    tk("t41", 8'h41, 1, 0, 0);
    tk("t42", 8'h42, 1, 0, 0);
    cmd("load_in_run", OP_LOAD, 8'h11, 1'b0, 8'h42, 1, 1);
    nop("gap1", 8'h42, 1);
    cmd("stop_with_tick", OP_STOP, 8'h00, 1'b1, 8'h42, 0, 0);
    nop("gap2", 8'h42, 0);
    cmd("load_3A_bad", OP_LOAD, 8'h3A, 1'b0, 8'h42, 0, 1);
    nop("gap3", 8'h42, 0);
    tk("tick_idle", 8'h42, 0, 0, 0);

    // Auto-reload at limit 05
    cmd("clear", OP_CLEAR, 8'h00, 1'b0, 8'h00, 0, 0);
    nop("gap4", 8'h00, 0);
    limit = 8'h05; reload = 1'b1;
    cmd("start_rl", OP_START, 8'h00, 1'b0, 8'h00, 1, 0);
    for (int i = 0; i < 12; i++) tk($sformatf("rl_tick%0d", i + 1), r_cnt[i], 1, r_dn[i], 0);
    cmd("stop_rl", OP_STOP, 8'h00, 1'b0, 8'h00, 0, 0);
    nop("gap5", 8'h00, 0);

    // One-shot at limit 03
    limit = 8'h03; reload = 1'b0;
    cmd("start_os", OP_START, 8'h00, 1'b0, 8'h00, 1, 0);
    tk("os_t1", 8'h01, 1, 0, 0);
    tk("os_t2", 8'h02, 1, 0, 0);
    tk("os_t3", 8'h03, 1, 0, 0);
    tk("os_t4_done", 8'h03, 0, 1, 0);
    tk("os_t5_hold", 8'h03, 0, 0, 0);
    tk("os_t6_hold", 8'h03, 0, 0, 0);
    cmd("restart_done", OP_START, 8'h00, 1'b0, 8'h00, 1, 0);
    nop("gap6", 8'h00, 1);
    cmd("stop_os", OP_STOP, 8'h00, 1'b0, 8'h00, 0, 0);
    nop("gap7", 8'h00, 0);

    // Overflow with non-matching limit
    limit = 8'hFF;
    cmd("load98", OP_LOAD, 8'h98, 1'b0, 8'h98, 0, 0);
    nop("gap8", 8'h98, 0);
    cmd("start_ov", OP_START, 8'h00, 1'b0, 8'h98, 1, 0);
    tk("ov_99", 8'h99, 1, 0, 0);
    tk("ov_wrap", 8'h00, 1, 0, 1);
    tk("ov_01", 8'h01, 1, 0, 0);

    // Reset mid-count while ticking and requesting a command
    clear_n = 1'b0;
    step("reset_mid", 1'b1, OP_LOAD, 8'h12, 1'b1, 8'h00, 0, 0, 0, 0, 1);
    clear_n = 1'b1;
    tk("after_reset_tick", 8'h00, 0, 0, 0);

    // CLEAR on the cycle the limit would hit suppresses done
    limit = 8'h01; reload = 1'b0;
    cmd("start_cl", OP_START, 8'h00, 1'b0, 8'h00, 1, 0);
    tk("cl_t1", 8'h01, 1, 0, 0);
    cmd("clear_at_limit", OP_CLEAR, 8'h00, 1'b1, 8'h00, 0, 0);
    nop("final", 8'h00, 0);

    cmd_valid = 1'b0; tick = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    #1;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
